// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: produces enable/flush strobes for the PC and the
// four stage latches, plus a saturating stall-cycle counter for perf debug.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dren,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rsel1,
  input  logic [4:0]       id_rsel2,
  input  logic             id_uses_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t state, next_state;
  logic   load_use;
  logic   dmiss;
  logic   advance;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Register zero is never really written, so it can never be a hazard source.
  assign load_use = ex_dren && (ex_wsel != 5'd0) &&
                    ((ex_wsel == id_rsel1) || (id_uses_rt && (ex_wsel == id_rsel2)));
  assign dmiss    = (mem_dren || mem_dwen) && !dhit;

  always_comb begin
    next_state  = state;
    advance     = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b0;

    case (state)
      S_RUN: begin
        if (mem_halt) begin
          // Let the halt retire into MEM/WB, freeze everything older.
          memwb_en   = 1'b1;
          next_state = S_HALT;
        end else if (dmiss) begin
          next_state = S_DWAIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_DWAIT: begin
        if (dhit) begin
          advance    = 1'b1;
          next_state = S_RUN;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: next_state = S_RUN;
    endcase

    // Redirect > load-use > ifetch miss > full advance, shared by RUN and DWAIT.
    if (advance) begin
      if (mem_redirect) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
      end else if (load_use) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end

    if (RST) begin
      next_state  = S_RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      halted      = 1'b0;
    end
  end

  // State register and stall counter (HALT cycles are not stalls).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RUN;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (!pc_en && (state != S_HALT))
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed strobe vectors per cycle,
// plus a CNT_W=4 instance sharing the stimulus for counter saturation.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt;
  logic        ex_dren, id_uses_rt;
  logic [4:0]  ex_wsel, id_rsel1, id_rsel2;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, halted;
  logic [15:0] stall_cnt;

  logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4;
  logic        exmem_en4, exmem_flush4, memwb_en4, halted4;
  logic [3:0]  stall_cnt4;

  logic [8:0]  outs;

  int n_checks = 0;
  int n_errors = 0;

  // Output vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en halted
  localparam logic [8:0] O_ZERO   = 9'b000000000;
  localparam logic [8:0] O_NORM   = 9'b110101010;
  localparam logic [8:0] O_LU     = 9'b000111010;
  localparam logic [8:0] O_REDIR  = 9'b111111110;
  localparam logic [8:0] O_MISS   = 9'b011101010;
  localparam logic [8:0] O_HALTR  = 9'b000000010;
  localparam logic [8:0] O_HALTED = 9'b000000001;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect),
    .mem_halt(mem_halt), .ex_dren(ex_dren), .ex_wsel(ex_wsel),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_uses_rt(id_uses_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect),
    .mem_halt(mem_halt), .ex_dren(ex_dren), .ex_wsel(ex_wsel),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_uses_rt(id_uses_rt),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
    .idex_en(idex_en4), .idex_flush(idex_flush4), .exmem_en(exmem_en4),
    .exmem_flush(exmem_flush4), .memwb_en(memwb_en4), .halted(halted4),
    .stall_cnt(stall_cnt4)
  );

  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush, memwb_en, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set at a negedge; check strobes and counter, move to next negedge.
  task automatic cyc(input string tag, input logic [8:0] exp_o, input int exp_c);
    #1;
    check(tag, {23'd0, outs}, {23'd0, exp_o});
    check({tag, "_cnt"}, {16'd0, stall_cnt}, exp_c);
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0; ex_dren = 1'b0; id_uses_rt = 1'b0;
    ex_wsel = 5'd0; id_rsel1 = 5'd0; id_rsel2 = 5'd0;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    ihit = 1'b0;
    @(negedge CLK);
    cyc("rst0", O_ZERO, 0);
    cyc("rst1", O_ZERO, 0);

    RST = 1'b0; ihit = 1'b1;
    cyc("norm", O_NORM, 0);

    // Load-use on rs, then on rt, and the register-zero exemption
    ex_dren = 1'b1; ex_wsel = 5'd5; id_rsel1 = 5'd5;
    cyc("lu_rs", O_LU, 0);
    ex_dren = 1'b0;
    cyc("lu_done", O_NORM, 1);
    ex_dren = 1'b1; ex_wsel = 5'd0; id_rsel1 = 5'd0;
    cyc("lu_r0", O_NORM, 1);
    ex_wsel = 5'd7; id_rsel1 = 5'd3; id_rsel2 = 5'd7; id_uses_rt = 1'b1;
    cyc("lu_rt", O_LU, 1);
    id_uses_rt = 1'b0;
    cyc("lu_rt_unused", O_NORM, 2);
    clear_inputs();

    // Data-cache wait: 3 frozen cycles, redirect ignored while waiting
    mem_dren = 1'b1; dhit = 1'b0;
    cyc("dw0", O_ZERO, 2);
    mem_redirect = 1'b1;
    cyc("dw1", O_ZERO, 3);
    mem_redirect = 1'b0;
    cyc("dw2", O_ZERO, 4);
    dhit = 1'b1;
    cyc("dw_done", O_NORM, 5);
    mem_dren = 1'b0; dhit = 1'b0;
    cyc("after_dw", O_NORM, 5);

    // Store miss, then completion coincident with load-use
    mem_dwen = 1'b1;
    cyc("sw_miss", O_ZERO, 5);
    dhit = 1'b1; ex_dren = 1'b1; ex_wsel = 5'd9; id_rsel1 = 5'd9;
    cyc("dw_lu", O_LU, 6);
    clear_inputs();
    cyc("dw_lu_done", O_NORM, 7);
    mem_dren = 1'b1; dhit = 1'b1;
    cyc("dhit_run", O_NORM, 7);
    clear_inputs();

    // Redirect overrides ifetch miss; the miss is then seen next cycle
    mem_redirect = 1'b1; ihit = 1'b0;
    cyc("redir", O_REDIR, 7);
    mem_redirect = 1'b0;
    cyc("redir_miss", O_MISS, 7);
    ihit = 1'b1;
    cyc("refetch", O_NORM, 8);

    // Halt beats everything, then the pipeline stays frozen
    mem_halt = 1'b1; ex_dren = 1'b1; ex_wsel = 5'd5; id_rsel1 = 5'd5;
    ihit = 1'b0; mem_redirect = 1'b1; mem_dren = 1'b1;
    cyc("halt_pri", O_HALTR, 8);
    for (int i = 0; i < 10; i++) begin
      {ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt, ex_dren, id_uses_rt} = 8'($urandom);
      ex_wsel = 5'($urandom); id_rsel1 = ex_wsel; id_rsel2 = 5'($urandom);
      cyc("halted", O_HALTED, 9);
    end
    RST = 1'b1;
    cyc("rst_halt", O_ZERO, 9);
    RST = 1'b0;
    clear_inputs();
    cyc("post_rst", O_NORM, 0);

    // Counter saturation on the 4-bit instance
    ihit = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      #1;
      check("sat_cnt4", {28'd0, stall_cnt4}, (i > 15) ? 15 : i);
      #0;
      cyc("sat_miss", O_MISS, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
